// File: rtl/xga_scan_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : xga_scan_timer                                           |
// | Description : 1024x768 raster timing generator. x is split into a      |
// |               32-pixel tile and offset; y is carried as a quotient/    |
// |               remainder pair by Y_DIV. Optional frame counter is       |
// |               enabled by defining XGA_SCAN_FRAME_CNT_EN.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module xga_scan_timer #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned Y_DIV    = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi,
  output logic       line_start,
  output logic       frame_start
`ifdef XGA_SCAN_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam int unsigned c_V_LAST     = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;
  localparam int unsigned c_VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned c_VS_END     = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [4:0]  c_YL_HI      = 5'(c_V_LAST / Y_DIV);
  localparam logic [5:0]  c_YL_LO      = 6'(c_V_LAST % Y_DIV);
  localparam logic [5:0]  c_YDIV_LAST  = 6'(Y_DIV - 1);
  localparam logic [4:0]  c_VA_HI      = 5'(V_ACTIVE / Y_DIV);
  localparam logic [5:0]  c_VA_LO      = 6'(V_ACTIVE % Y_DIV);
  localparam logic [4:0]  c_VS_HI      = 5'(c_VS_START / Y_DIV);
  localparam logic [5:0]  c_VS_LO      = 6'(c_VS_START % Y_DIV);
  localparam logic [4:0]  c_VE_HI      = 5'(c_VS_END / Y_DIV);
  localparam logic [5:0]  c_VE_LO      = 6'(c_VS_END % Y_DIV);

  // Ordering on the (hi, lo) pair stands in for a compare on y itself.
  function automatic logic y_ge(input logic [4:0] hi, input logic [5:0] lo,
                                input logic [4:0] k_hi, input logic [5:0] k_lo);
    return (hi > k_hi) || ((hi == k_hi) && (lo >= k_lo));
  endfunction

  logic [10:0] r_x;
  logic [5:0]  r_y_lo;
  logic [4:0]  r_y_hi;
  logic        r_hsync, r_vsync, r_blank, r_line_start, r_frame_start;

  logic        w_x_wrap;
  logic [10:0] w_x_nxt;
  logic [5:0]  w_y_lo_nxt;
  logic [4:0]  w_y_hi_nxt;
  logic        w_hsync_nxt, w_vsync_nxt, w_blank_nxt, w_line_nxt, w_frame_nxt;

  always_comb begin
    w_x_wrap   = (r_x == c_H_LAST);
    w_x_nxt    = w_x_wrap ? 11'd0 : r_x + 11'd1;
    w_y_lo_nxt = r_y_lo;
    w_y_hi_nxt = r_y_hi;
    if (w_x_wrap) begin
      if ((r_y_hi == c_YL_HI) && (r_y_lo == c_YL_LO)) begin
        w_y_lo_nxt = 6'd0;
        w_y_hi_nxt = 5'd0;
      end else if (r_y_lo == c_YDIV_LAST) begin
        w_y_lo_nxt = 6'd0;
        w_y_hi_nxt = r_y_hi + 5'd1;
      end else begin
        w_y_lo_nxt = r_y_lo + 6'd1;
      end
    end

    // Decoded from next-state so each flag lines up with its x/y.
    w_blank_nxt = (w_x_nxt >= c_H_ACT) || y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VA_HI, c_VA_LO);
    w_hsync_nxt = !((w_x_nxt >= c_HS_START) && (w_x_nxt < c_HS_END));
    w_vsync_nxt = !(y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VS_HI, c_VS_LO) &&
                    !y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VE_HI, c_VE_LO));
    w_line_nxt  = (w_x_nxt == 11'd0);
    w_frame_nxt = w_line_nxt && (w_y_hi_nxt == 5'd0) && (w_y_lo_nxt == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x           <= 11'd0;
      r_y_lo        <= 6'd0;
      r_y_hi        <= 5'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else begin
      r_x           <= w_x_nxt;
      r_y_lo        <= w_y_lo_nxt;
      r_y_hi        <= w_y_hi_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_blank       <= w_blank_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign x_lo        = r_x[4:0];
  assign x_hi        = r_x[10:5];
  assign y_lo        = r_y_lo;
  assign y_hi        = r_y_hi;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef XGA_SCAN_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Reset-forced frame_start is excluded: reset branch wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_nxt) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xga_scan_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_xga_scan_timer                                        |
// | Description : Checks a full-size and a shrunk timer against a model    |
// |               that derives x/y from the cycle count since reset.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_xga_scan_timer;

  // Shrunk geometry: 8 clocks x 10 lines, Y_DIV = 4, so frames wrap quickly.
  localparam int c_SHA = 4, c_SHF = 1, c_SHS = 2, c_SHB = 1;
  localparam int c_SVA = 6, c_SVF = 1, c_SVS = 2, c_SVB = 1, c_SYD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_hsync, a_vsync, a_blank, a_ls, a_fs;
  logic [4:0] a_x_lo;  logic [5:0] a_x_hi;
  logic [5:0] a_y_lo;  logic [4:0] a_y_hi;
  logic [7:0] a_fc;
  logic       b_hsync, b_vsync, b_blank, b_ls, b_fs;
  logic [4:0] b_x_lo;  logic [5:0] b_x_hi;
  logic [5:0] b_y_lo;  logic [4:0] b_y_hi;
  logic [7:0] b_fc;

  int     tests = 0;
  int     fails = 0;
  longint t_a   = 0;
  longint t_b   = 0;

  always #5 clk = ~clk;

  xga_scan_timer u_dut_a (
    .clk(clk), .rst_n(rst_n), .hsync(a_hsync), .vsync(a_vsync), .blank(a_blank),
    .x_lo(a_x_lo), .x_hi(a_x_hi), .y_lo(a_y_lo), .y_hi(a_y_hi),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef XGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  xga_scan_timer #(
    .H_ACTIVE(c_SHA), .H_FP(c_SHF), .H_SYNC(c_SHS), .H_BP(c_SHB),
    .V_ACTIVE(c_SVA), .V_FP(c_SVF), .V_SYNC(c_SVS), .V_BP(c_SVB), .Y_DIV(c_SYD)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hsync(b_hsync), .vsync(b_vsync), .blank(b_blank),
    .x_lo(b_x_lo), .x_hi(b_x_hi), .y_lo(b_y_lo), .y_hi(b_y_hi),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef XGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

`ifndef XGA_SCAN_FRAME_CNT_EN
  assign a_fc = 8'd0;
  assign b_fc = 8'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: position is simply the clock count since reset release.
  task automatic check_dut(input string who, input longint t,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb, input int yd,
                           input logic o_hs, input logic o_vs, input logic o_bl,
                           input logic [4:0] o_xlo, input logic [5:0] o_xhi,
                           input logic [5:0] o_ylo, input logic [4:0] o_yhi,
                           input logic o_ls, input logic o_fs, input logic [7:0] o_fc);
    longint ht, vt, x, y, fr;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = t % ht;
    y  = (t / ht) % vt;
    fr = t / (ht * vt);
    chk({who, " x_lo"},  32'(o_xlo), 32'(x % 32));
    chk({who, " x_hi"},  32'(o_xhi), 32'(x / 32));
    chk({who, " y_lo"},  32'(o_ylo), 32'(y % yd));
    chk({who, " y_hi"},  32'(o_yhi), 32'(y / yd));
    chk({who, " blank"}, 32'(o_bl),  32'((x >= ha) || (y >= va)));
    chk({who, " hsync"}, 32'(o_hs),  32'(!((x >= ha + hf) && (x < ha + hf + hs))));
    chk({who, " vsync"}, 32'(o_vs),  32'(!((y >= va + vf) && (y < va + vf + vs))));
    chk({who, " line_start"},  32'(o_ls), 32'(x == 0));
    chk({who, " frame_start"}, 32'(o_fs), 32'((x == 0) && (y == 0)));
`ifdef XGA_SCAN_FRAME_CNT_EN
    chk({who, " frame_cnt"}, 32'(o_fc), 32'(fr % 256));
`else
    if (o_fc !== 8'd0) $display("note: %s frame_cnt tie-off %0d, frame %0d", who, o_fc, fr);
`endif
  endtask

  task automatic tick(input logic r);
    rst_n = r;
    @(posedge clk);
    if (!r) begin
      t_a = 0;
      t_b = 0;
    end else begin
      t_a++;
      t_b++;
    end
    #1;
    check_dut("A", t_a, 1024, 24, 136, 160, 768, 3, 6, 29, 48,
              a_hsync, a_vsync, a_blank, a_x_lo, a_x_hi, a_y_lo, a_y_hi, a_ls, a_fs, a_fc);
    check_dut("B", t_b, c_SHA, c_SHF, c_SHS, c_SHB, c_SVA, c_SVF, c_SVS, c_SVB, c_SYD,
              b_hsync, b_vsync, b_blank, b_x_lo, b_x_hi, b_y_lo, b_y_hi, b_ls, b_fs, b_fc);
  endtask

  initial begin
    int n;
    // Reset state held across several edges.
    repeat (3) tick(1'b0);
    // More than one full line: x wrap, hsync window, line_start.
    repeat (1400) tick(1'b1);
    // Resets dropped at random points, random length.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(50, 3000);
      repeat (n) tick(1'b1);
      n = $urandom_range(1, 4);
      repeat (n) tick(1'b0);
    end
    // Long clean run: shrunk timer wraps 257 frames (frame_cnt 255 -> 0 -> 1).
    repeat (2) tick(1'b0);
    repeat (257 * 80 + 40) tick(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xga_scan_timer.md
Name: xga_scan_timer

Overview:
- Raster timing generator for the 1024x768 VGA scope peripheral; sits directly upstream of the pixel/shift-register stage.
- Produces hsync, vsync and blank, plus the current pixel position.
- x is delivered split into a 32-pixel tile index and an offset within the tile.
- y is delivered as a quotient/remainder by 48 (y = y_hi*48 + y_lo), so downstream needs only shifts and adds, no divider.
- Runs off the 64 MHz TinyQV clock, one pixel per clock (~59 Hz frame).

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch (clocks); H_TOTAL = 1344
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = 806
- Y_DIV, 48, divisor for the y_hi/y_lo split

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high outside the 1024x768 active area
- x_lo  out  5  pixel x mod 32
- x_hi  out  6  pixel x div 32
- y_lo  out  6  line y mod 48, range 0..47
- y_hi  out  5  line y div 48, range 0..16
- line_start  out  1  one-clock pulse when x = 0
- frame_start  out  1  one-clock pulse when x = 0 and y = 0
- frame_cnt  out  8  frame counter; present only with the optional feature

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - x = 0, y_hi = 0, y_lo = 0.
  - hsync = 1, vsync = 1, blank = 0.
  - line_start = 1, frame_start = 1.
  - All of these hold while reset is asserted.
  - Reset mid-line or mid-frame restarts at (0,0) on the next edge with no partial pulses.
- Horizontal counter x (11 bits, {x_hi, x_lo}):
  - Increments every clock, 0..H_TOTAL-1 (1343).
  - Wraps to 0 on the following clock; 1343 -> 0 in one step, with no skipped or repeated value.
- Vertical counter:
  - Advances only on the clock where x wraps 1343 -> 0.
  - y_lo increments; when y_lo = 47, y_lo -> 0 and y_hi increments.
  - When y = V_TOTAL-1 (y_hi = 16, y_lo = 37), both wrap to 0.
  - The y_hi/y_lo pair must never reach y_lo = 48.
  - No multiplier or divider: y is carried only as the pair.
- Derived outputs: registered, computed from next-state counters so they are exactly aligned with the x/y values present in the same cycle (zero relative latency).
  - blank = (x >= 1024) or (y >= 768). y >= 768 ⇔ y_hi = 16.
  - hsync = 0 iff 1048 <= x <= 1183 (H_ACTIVE+H_FP .. +H_SYNC-1).
  - vsync = 0 iff 771 <= y <= 776, i.e. y_hi = 16 and 3 <= y_lo <= 8. vsync changes only on line boundaries (x = 0).
  - line_start = 1 iff x = 0.
  - frame_start = 1 iff x = 0 and y = 0.
- Simultaneous wrap:
  - At x = 1343, y = 805, the next cycle has x = 0, y = 0.
  - frame_start and line_start are both high in that cycle; blank drops to 0.
- Comparisons against parameters use 11-bit unsigned arithmetic. Parameter sums must fit in 11 bits; out-of-range values are not supported.

Optional Feature:
- Macro XGA_SCAN_FRAME_CNT_EN.
- Defined:
  - frame_cnt port exists, reset to 0.
  - Increments (mod 256) in the same cycle frame_start is high, so its value changes coincident with frame_start.
  - Wraps 255 -> 0.
  - Not incremented by the reset-forced frame_start.
- Undefined: the frame_cnt port and register are absent; all other behaviour is identical.

Test Plan:
- Reset then run 1344 clocks:
  - x_hi/x_lo sequence 0..1343 then 0.
  - line_start high only at x = 0.
  - hsync low for exactly 136 clocks starting at x = 1048.
- Run a full frame (1344*806 = 1,083,264 clocks):
  - frame_start high exactly once, at the start.
  - y_hi/y_lo go 0/0 -> 0/47 -> 1/0 -> ... -> 16/37 -> 0/0.
- Blank check:
  - blank = 0 for x = 1023, y = 767 (y_hi = 15, y_lo = 47).
  - blank = 1 at x = 1024 on any line.
  - blank = 1 on every pixel while y_hi = 16.
- vsync check:
  - vsync falls at x = 0 of y_hi = 16, y_lo = 3.
  - vsync rises at x = 0 of y_hi = 16, y_lo = 9 (6 lines = 8064 clocks low).
- Assert rst_n = 0 at x = 700, y_hi = 5, y_lo = 20 for 3 clocks, then release:
  - Outputs read (0,0), hsync = 1, vsync = 1, blank = 0 during reset.
  - Counting resumes from x = 0 at release.
- With XGA_SCAN_FRAME_CNT_EN, run 257 frames:
  - frame_cnt goes 1, 2, ..., 255, 0, 1.
  - Each change coincides with frame_start.
  - Without the macro, the same bench compiles with no frame_cnt port.
